// File: rtl/wb_result_stage_pkg.sv
// Shared encodings and the registered control payload for the writeback result stage.
package wb_result_stage_pkg;

    localparam int unsigned RD_W = 5;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;
    localparam logic [1:0] RES_IMM = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic            reg_write;
        logic            misalign;
    } wb_ctrl_t;

endpackage

// File: rtl/wb_result_stage_load_extend.sv
// Combinational load extraction and sign/zero extension with misalign detection.
module load_extend
    import wb_result_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_load,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data_c,
    output logic            misalign_c
);

    logic [31:0] word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        word     = rdata[31:0];
        byte_sel = word[7:0];
        case (addr_lo)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        misalign_c = is_load &&
                     ((((funct3 == F3_LH) || (funct3 == F3_LHU)) && addr_lo[0]) ||
                      ((funct3 == F3_LW) && (addr_lo != 2'd0)));

        // A misaligned access forwards the raw word untouched.
        data_c = rdata;
        if (!misalign_c) begin
            case (funct3)
                F3_LB:   data_c = XLEN'($signed(byte_sel));
                F3_LH:   data_c = XLEN'($signed(half_sel));
                F3_LW:   data_c = XLEN'($signed(word));
                F3_LBU:  data_c = XLEN'(byte_sel);
                F3_LHU:  data_c = XLEN'(half_sel);
                default: data_c = rdata;
            endcase
        end
    end

endmodule

// File: rtl/wb_result_stage.sv
// One-entry writeback pipeline register: selects the result source and qualifies the register write.
module wb_result_stage
    import wb_result_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NSRC = 4,
    parameter int unsigned SELW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] ALUResult,
    input  logic [XLEN-1:0] ReadData,
    input  logic [XLEN-1:0] PCPlus4,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [SELW-1:0] ResultSrc,
    input  logic [2:0]      Funct3,
    input  logic [4:0]      RdIn,
    input  logic            RegWriteIn,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic [4:0]      RdOut,
    output logic            RegWriteOut,
    output logic            Misalign
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;
    wb_ctrl_t        ctrl_q, ctrl_d;

    logic            is_load_c;
    logic            capture_c;
    logic            misalign_c;
    logic [XLEN-1:0] load_data_c;
    logic [XLEN-1:0] sel_data_c;

    assign is_load_c = (ResultSrc == SELW'(RES_MEM));
    assign in_ready  = !valid_q || out_ready;
    assign capture_c = in_valid && in_ready && !flush;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .is_load    (is_load_c),
        .addr_lo    (ALUResult[1:0]),
        .funct3     (Funct3),
        .rdata      (ReadData),
        .data_c     (load_data_c),
        .misalign_c (misalign_c)
    );

    // Source select; with only three sources the spare code falls back to the ALU.
    always_comb begin
        sel_data_c = ALUResult;
        case (ResultSrc)
            SELW'(RES_MEM): sel_data_c = load_data_c;
            SELW'(RES_PC4): sel_data_c = PCPlus4;
            SELW'(RES_IMM): sel_data_c = (NSRC == 4) ? ImmExt : ALUResult;
            default:        sel_data_c = ALUResult;
        endcase
    end

    // Entry update: flush beats capture beats drain; an empty entry always reads zero.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        ctrl_d   = ctrl_q;
        if (flush) begin
            valid_d  = 1'b0;
            result_d = '0;
            ctrl_d   = '0;
        end else if (capture_c) begin
            valid_d          = 1'b1;
            result_d         = sel_data_c;
            ctrl_d.rd        = RdIn;
            ctrl_d.reg_write = RegWriteIn && (RdIn != 5'd0) && !misalign_c;
            ctrl_d.misalign  = misalign_c;
        end else if (valid_q && out_ready) begin
            valid_d  = 1'b0;
            result_d = '0;
            ctrl_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            ctrl_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign out_valid   = valid_q;
    assign Result      = result_q;
    assign RdOut       = ctrl_q.rd;
    assign RegWriteOut = ctrl_q.reg_write;
    assign Misalign    = ctrl_q.misalign;

endmodule

// File: tb/tb_wb_result_stage.sv
// Directed, table-driven bench for wb_result_stage with hand-written handshake, flush and reset sequences.
module tb_wb_result_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ALUResult;
    logic [31:0] ReadData;
    logic [31:0] PCPlus4;
    logic [31:0] ImmExt;
    logic [1:0]  ResultSrc;
    logic [2:0]  Funct3;
    logic [4:0]  RdIn;
    logic        RegWriteIn;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic [4:0]  RdOut;
    logic        RegWriteOut;
    logic        Misalign;

    int checks;
    int failures;

    wb_result_stage #(.XLEN(32), .NSRC(4), .SELW(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ALUResult   (ALUResult),
        .ReadData    (ReadData),
        .PCPlus4     (PCPlus4),
        .ImmExt      (ImmExt),
        .ResultSrc   (ResultSrc),
        .Funct3      (Funct3),
        .RdIn        (RdIn),
        .RegWriteIn  (RegWriteIn),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Result      (Result),
        .RdOut       (RdOut),
        .RegWriteOut (RegWriteOut),
        .Misalign    (Misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] exp_result;
        logic        exp_rw;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [1:0] src, input logic [4:0] rd);
        ALUResult  = alu;
        ReadData   = 32'h0;
        PCPlus4    = 32'h0;
        ImmExt     = 32'h0;
        ResultSrc  = src;
        Funct3     = 3'b010;
        RdIn       = rd;
        RegWriteIn = 1'b1;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_result"}, Result, 32'd0);
        check({tag, "_rd"}, 32'(RdOut), 32'd0);
        check({tag, "_rw"}, 32'(RegWriteOut), 32'd0);
        check({tag, "_mis"}, 32'(Misalign), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        flush    = 1'b0;
        drive(32'h0, 2'd0, 5'd0);
        RegWriteIn = 1'b0;

        //                alu          rdata        pc4     imm         src   f3      rd  rw  result       rw  mis
        vecs.push_back('{32'h4, 32'h8,        32'h4, 32'h1000, 2'd0, 3'b010, 5'd1, 1'b1, 32'h4,        1'b1, 1'b0});
        vecs.push_back('{32'h4, 32'h8,        32'h4, 32'h1000, 2'd1, 3'b010, 5'd1, 1'b1, 32'h8,        1'b1, 1'b0});
        vecs.push_back('{32'h4, 32'h8,        32'h4, 32'h1000, 2'd2, 3'b010, 5'd1, 1'b1, 32'h4,        1'b1, 1'b0});
        vecs.push_back('{32'h4, 32'h8,        32'h4, 32'h1000, 2'd3, 3'b010, 5'd1, 1'b1, 32'h1000,     1'b1, 1'b0});
        vecs.push_back('{32'h3, 32'h80FF7F01, 32'h0, 32'h0,    2'd1, 3'b000, 5'd2, 1'b1, 32'hFFFFFF80, 1'b1, 1'b0});
        vecs.push_back('{32'h3, 32'h80FF7F01, 32'h0, 32'h0,    2'd1, 3'b100, 5'd2, 1'b1, 32'h00000080, 1'b1, 1'b0});
        vecs.push_back('{32'h2, 32'h80FF7F01, 32'h0, 32'h0,    2'd1, 3'b001, 5'd3, 1'b1, 32'hFFFF80FF, 1'b1, 1'b0});
        vecs.push_back('{32'h0, 32'h80FF7F01, 32'h0, 32'h0,    2'd1, 3'b101, 5'd3, 1'b1, 32'h00007F01, 1'b1, 1'b0});
        vecs.push_back('{32'h1, 32'h80FF7F01, 32'h0, 32'h0,    2'd1, 3'b000, 5'd4, 1'b1, 32'h0000007F, 1'b1, 1'b0});
        vecs.push_back('{32'h2, 32'h80FF7F01, 32'h0, 32'h0,    2'd1, 3'b000, 5'd4, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0});
        vecs.push_back('{32'h6, 32'h80FF7F01, 32'h0, 32'h0,    2'd1, 3'b010, 5'd5, 1'b1, 32'h80FF7F01, 1'b0, 1'b1});
        vecs.push_back('{32'h1, 32'h12345678, 32'h0, 32'h0,    2'd1, 3'b001, 5'd6, 1'b1, 32'h12345678, 1'b0, 1'b1});
        vecs.push_back('{32'h3, 32'h12345678, 32'h0, 32'h0,    2'd1, 3'b101, 5'd6, 1'b1, 32'h12345678, 1'b0, 1'b1});
        vecs.push_back('{32'h9, 32'h0,        32'h0, 32'h0,    2'd0, 3'b010, 5'd0, 1'b1, 32'h9,        1'b0, 1'b0});
        vecs.push_back('{32'hA, 32'h0,        32'h0, 32'h0,    2'd0, 3'b010, 5'd7, 1'b0, 32'hA,        1'b0, 1'b0});
        vecs.push_back('{32'h6, 32'h55,       32'h0, 32'h0,    2'd0, 3'b010, 5'd8, 1'b1, 32'h6,        1'b1, 1'b0});
        vecs.push_back('{32'h2, 32'hCAFEF00D, 32'h0, 32'h0,    2'd1, 3'b011, 5'd9, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0});

        // Reset state
        step();
        check_empty("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        check("post_reset_valid", 32'(out_valid), 32'd0);

        // Table: one instruction per cycle, consumer always ready
        for (int i = 0; i < vecs.size(); i++) begin
            ALUResult  = vecs[i].alu;
            ReadData   = vecs[i].rdata;
            PCPlus4    = vecs[i].pc4;
            ImmExt     = vecs[i].imm;
            ResultSrc  = vecs[i].src;
            Funct3     = vecs[i].f3;
            RdIn       = vecs[i].rd;
            RegWriteIn = vecs[i].rw;
            in_valid   = 1'b1;
            out_ready  = 1'b1;
            step();
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_result", i), Result, vecs[i].exp_result);
            check($sformatf("vec%0d_rd", i), 32'(RdOut), 32'(vecs[i].rd));
            check($sformatf("vec%0d_rw", i), 32'(RegWriteOut), 32'(vecs[i].exp_rw));
            check($sformatf("vec%0d_mis", i), 32'(Misalign), 32'(vecs[i].exp_mis));
        end
        in_valid = 1'b0;
        step();
        check_empty("drain");

        // Back-pressure: entry A held for three cycles while B waits
        drive(32'h111, 2'd0, 5'd7);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        check("bp_load_result", Result, 32'h111);
        drive(32'h222, 2'd0, 5'd8);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
            step();
            check($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_result", c), Result, 32'h111);
            check($sformatf("bp%0d_rd", c), 32'(RdOut), 32'd7);
            check($sformatf("bp%0d_rw", c), 32'(RegWriteOut), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_result", Result, 32'h222);
        check("bp_next_rd", 32'(RdOut), 32'd8);
        in_valid = 1'b0;
        step();
        check_empty("bp_drain");

        // Flush of a stalled entry while a new instruction is offered
        drive(32'h333, 2'd0, 5'd9);
        in_valid = 1'b1;
        step();
        check("fl_load_valid", 32'(out_valid), 32'd1);
        drive(32'h444, 2'd0, 5'd10);
        out_ready = 1'b0;
        flush     = 1'b1;
        step();
        check_empty("flush");
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("fl_after_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a stall
        drive(32'h555, 2'd0, 5'd11);
        in_valid = 1'b1;
        step();
        check("ar_load_valid", 32'(out_valid), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_empty("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("ar_in_ready", 32'(in_ready), 32'd1);
        check_empty("ar_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_result_stage.md
WB_RESULT_STAGE -- requirements
Module: wb_result_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits; legal values 32 or 64.
REQ-002 Parameter NSRC, default 4, number of result sources; legal values 3 or 4.
REQ-003 Parameter SELW, default 2, ResultSrc width; equals $clog2(NSRC).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  upstream presents a retiring instruction.
REQ-007 in_ready  output  1  stage can accept this cycle.
REQ-008 ALUResult  input  XLEN  ALU output; bits [1:0] also give the load byte offset.
REQ-009 ReadData  input  XLEN  raw aligned data-memory word.
REQ-010 PCPlus4  input  XLEN  link value for JAL/JALR.
REQ-011 ImmExt  input  XLEN  upper immediate for LUI; ignored when NSRC=3.
REQ-012 ResultSrc  input  SELW  0=ALUResult, 1=extended load data, 2=PCPlus4, 3=ImmExt.
REQ-013 Funct3  input  3  load size and sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-014 RdIn  input  5  destination register.
REQ-015 RegWriteIn  input  1  instruction writes Rd.
REQ-016 flush  input  1  synchronous kill of the held entry and of the current input.
REQ-017 out_valid  output  1  registered result is valid.
REQ-018 out_ready  input  1  register file or consumer accepts this cycle.
REQ-019 Result  output  XLEN  registered writeback value.
REQ-020 RdOut  output  5  registered destination.
REQ-021 RegWriteOut  output  1  registered write enable, qualified as defined in REQ-027.
REQ-022 Misalign  output  1  registered flag: the load access was misaligned.

Function
REQ-023 The block is a one-entry pipeline register. in_ready = !out_valid || out_ready, combinational.
REQ-024 Capture occurs when in_valid && in_ready && !flush. The entry loads on the next edge, so latency is one cycle.
REQ-025 Load extraction:
  - The byte or halfword is selected by ALUResult[1:0].
  - LB/LH sign-extend to XLEN; LBU/LHU zero-extend.
  - LW passes bits [31:0], sign-extended to XLEN.
  - Any other Funct3 passes ReadData unchanged.
REQ-026 Misalign = 1 when ResultSrc=1 and either:
  - LH/LHU with ALUResult[0]=1, or
  - LW with ALUResult[1:0]!=0.
  In that case Result holds the unextracted ReadData.
REQ-027 RegWriteOut = RegWriteIn && (RdIn!=0) && !Misalign. x0 is never written.
REQ-028 When NSRC=3, ResultSrc=3 selects ALUResult.
REQ-029 Handshake:
  - out_valid && !out_ready holds every output stable.
  - out_valid && out_ready with no capture clears out_valid next cycle.
  - Simultaneous consume and capture replaces the entry with no bubble.
REQ-030 flush has priority over capture and over hold. On the next edge out_valid=0, and RegWriteOut and Misalign read 0.
REQ-031 While out_valid=0, Result, RdOut, RegWriteOut and Misalign read 0.

Reset
REQ-032 rst_n=0 immediately forces out_valid=0, Result=0, RdOut=0, RegWriteOut=0 and Misalign=0, regardless of clk.
REQ-033 Deassertion takes effect at the first rising edge after rst_n=1. in_ready=1 in the first cycle after reset.
REQ-034 Reset in the middle of a stall discards the held entry; no write is issued for it.

Structure
REQ-035 A shared package holds:
  - ResultSrc encodings RES_ALU, RES_MEM, RES_PC4, RES_IMM.
  - Funct3 load encodings F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
REQ-036 Load extraction and misalign detection form one combinational sub-module, load_extend, parametrised by XLEN.

Verification
REQ-037 Select sweep:
  - Stimulus: ALUResult=0x4, ReadData=0x8, PCPlus4=0x4, ImmExt=0x1000, Funct3=010.
  - ResultSrc 0 to 3, one per cycle, out_ready=1.
  - Required: Result = 0x4, 0x8, 0x4, 0x1000, each one cycle later.
REQ-038 Load extension:
  - Stimulus: ReadData=0x80FF7F01, ResultSrc=1.
  - LB offset 3 -> 0xFFFFFF80.
  - LBU offset 3 -> 0x00000080.
  - LH offset 2 -> 0xFFFF80FF.
  - LHU offset 0 -> 0x00007F01.
REQ-039 Misalign:
  - Stimulus: LW with ALUResult=0x6, RegWriteIn=1, RdIn=5.
  - Required: Misalign=1, RegWriteOut=0, Result=ReadData.
REQ-040 Back-pressure:
  - Stimulus: out_ready=0 for 3 cycles with in_valid=1.
  - Required: in_ready=0 and outputs stable for those cycles.
  - Then out_ready=1 with in_valid=1: the next entry loads on that edge with no bubble.
REQ-041 x0 and flush:
  - RdIn=0 with RegWriteIn=1 -> RegWriteOut=0.
  - flush asserted with a stalled entry and in_valid=1 -> out_valid=0 next cycle.
REQ-042 Async reset:
  - Stimulus: rst_n pulled low between clock edges while out_valid=1.
  - Required: all outputs read 0 before the next edge.
